issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
Per-issue-slot register scoreboard between the instruction buffer and the operand-collection stage. It tracks in-flight destination registers per warp slot (wis). It holds back any instruction whose source or destination registers are still pending writeback (RAW/WAW). Hazard-free instructions pass through a one-entry output register to the operand stage.

Parameters:
ISSUE_RATIO, 4, warp slots per issue lane (inuse table rows)
NUM_REGS, 32, architectural registers per warp slot
NR_BITS, 5, register index width (clog2 NUM_REGS)
WIS_W, 2, warp-slot index width (max(1, clog2 ISSUE_RATIO))
DATAW, 64, opaque instruction payload width passed through unchanged
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ibuf_valid  in  1  instruction available from ibuffer
ibuf_ready  out  1  instruction accepted this cycle
ibuf_wis  in  WIS_W  warp slot of instruction
ibuf_wb  in  1  instruction writes rd
ibuf_rd  in  NR_BITS  destination register
ibuf_rs1  in  NR_BITS  source 1
ibuf_rs2  in  NR_BITS  source 2
ibuf_rs3  in  NR_BITS  source 3
ibuf_data  in  DATAW  payload
wb_valid  in  1  writeback beat valid
wb_wis  in  WIS_W  writeback warp slot
wb_rd  in  NR_BITS  writeback register
wb_eop  in  1  last beat of this writeback
out_valid  out  1  instruction to operand stage
out_data  out  DATAW+WIS_W+4*NR_BITS+1  {payload, wis, wb, rd, rs1, rs2, rs3} registered copy
out_ready  in  1  operand stage accepts
stall_cycles  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- State: inuse[ISSUE_RATIO][NUM_REGS] bit table; output register (out_valid, out_data); stall counter.
- Reset (sync, active-high): inuse all 0, out_valid=0, stall_cycles=0. out_data is don't-care while out_valid=0. Reset mid-operation drops the held instruction and all pending marks. Writebacks arriving after reset clear bits that are already 0, which is harmless.
- Release: when wb_valid && wb_eop && wb_rd!=0, clear inuse[wb_wis][wb_rd] at the clock edge. Non-eop beats do not release.
- Hazard check uses a release-bypassed view: inuse_q = inuse with this cycle's release already applied, so an instruction may issue in the same cycle its operand's eop writeback arrives.
- hazard = inuse_q[wis][rs1] | inuse_q[wis][rs2] | inuse_q[wis][rs3] | (ibuf_wb & inuse_q[wis][rd]). Register 0 never contributes (index 0 is masked).
- ibuf_ready = ibuf_valid & ~hazard & (~out_valid | out_ready). It is combinational from ibuf fields, inuse, wb inputs and out_ready.
- Acquire: on accept with ibuf_wb && ibuf_rd!=0, set inuse[ibuf_wis][ibuf_rd]. If a release and an acquire target the same bit in one cycle, the acquire wins (bit ends 1).
- Output register: on accept, load out_data and set out_valid=1 next cycle (latency 1). If out_valid && out_ready && no accept, then out_valid=0. out_data is stable while out_valid && ~out_ready.
- Throughput: 1 instr/cycle when there are no hazards and out_ready=1.
- Stall counter: +1 per cycle with ibuf_valid && hazard; saturates at all-ones. Backpressure-only stalls are not counted.
- Assertion (sim only): release of an inuse bit that is 0 (outside the first cycle after reset) is an error.
- Warp slots are independent: the same register in a different wis never conflicts.

Test Plan:
- Reset, then ibuf {wis=0, wb=1, rd=5, rs=1,2,3} with out_ready=1 -> ibuf_ready=1 at cycle 0, out_valid=1 at cycle 1, inuse[0][5]=1.
- Next instr wis=0 rs1=5 -> ibuf_ready=0 and stall_cycles increments each cycle. wb {wis=0, rd=5, eop=0} -> still stalled. Then eop=1 beat -> accepted in that same cycle.
- WAW: held instr wis=1 wb=1 rd=7 with inuse[1][7]=1 -> stalls. A wis=2 instr using rd=7 with the same pending mark -> issues immediately.
- r0: instr with rd=0, wb=1, rs1=rs2=rs3=0 issued back-to-back 4 times -> all accepted, no inuse bit set, stall_cycles unchanged.
- Backpressure: out_ready=0 with out_valid=1 -> ibuf_ready=0, out_data unchanged across 5 cycles, stall_cycles unchanged. out_ready=1 -> drains and accepts next instruction in the same cycle.
- Simultaneous eop release and new acquire of wis=0 rd=9 -> instruction accepted and inuse[0][9]=1 afterwards. Assert reset with inuse nonzero and out_valid=1 -> all cleared next cycle.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Per-warp-slot register scoreboard: holds back RAW/WAW hazards and
// forwards hazard-free instructions through a one-entry output register.
module issue_scoreboard #(
  parameter int ISSUE_RATIO = 4,
  parameter int NUM_REGS    = 32,
  parameter int NR_BITS     = 5,
  parameter int WIS_W       = 2,
  parameter int DATAW       = 64,
  parameter int CNT_W       = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ibuf_valid,
  output logic                             ibuf_ready,
  input  logic [WIS_W-1:0]                 ibuf_wis,
  input  logic                             ibuf_wb,
  input  logic [NR_BITS-1:0]               ibuf_rd,
  input  logic [NR_BITS-1:0]               ibuf_rs1,
  input  logic [NR_BITS-1:0]               ibuf_rs2,
  input  logic [NR_BITS-1:0]               ibuf_rs3,
  input  logic [DATAW-1:0]                 ibuf_data,
  input  logic                             wb_valid,
  input  logic [WIS_W-1:0]                 wb_wis,
  input  logic [NR_BITS-1:0]               wb_rd,
  input  logic                             wb_eop,
  output logic                             out_valid,
  output logic [DATAW+WIS_W+4*NR_BITS:0]   out_data,
  input  logic                             out_ready,
  output logic [CNT_W-1:0]                 stall_cycles
);

  logic [ISSUE_RATIO-1:0][NUM_REGS-1:0] inuse;
  logic [NUM_REGS-1:0] row_q;
  logic rel_en;
  logic acq_en;
  logic hazard;
  logic reset_d;

  assign rel_en = wb_valid & wb_eop & (wb_rd != '0);

  // Row for the requesting slot with this cycle's release bypassed in.
  always_comb begin
    row_q = inuse[ibuf_wis];
    if (rel_en && (wb_wis == ibuf_wis))
      row_q[wb_rd] = 1'b0;
    row_q[0] = 1'b0;
  end

  assign hazard = row_q[ibuf_rs1] | row_q[ibuf_rs2] |
                  row_q[ibuf_rs3] | (ibuf_wb & row_q[ibuf_rd]);

  assign ibuf_ready = ibuf_valid & ~hazard &
                      (~out_valid | out_ready);

  assign acq_en = ibuf_ready & ibuf_wb & (ibuf_rd != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      inuse        <= '0;
      out_valid    <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (rel_en)
        inuse[wb_wis][wb_rd] <= 1'b0;
      // Acquire is applied last so it wins over a same-bit release.
      if (acq_en)
        inuse[ibuf_wis][ibuf_rd] <= 1'b1;
      if (ibuf_ready)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;
      if (ibuf_valid && hazard && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ibuf_ready)
      out_data <= {ibuf_data, ibuf_wis, ibuf_wb, ibuf_rd,
                   ibuf_rs1, ibuf_rs2, ibuf_rs3};
  end

  always_ff @(posedge clk) begin
    reset_d <= reset;
  end

  always_ff @(posedge clk) begin
    if (!reset && !reset_d && rel_en)
      assert (inuse[wb_wis][wb_rd]);
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard.
module tb_issue_scoreboard;
  localparam int IR = 4;
  localparam int NR = 32;
  localparam int NB = 5;
  localparam int WW = 2;
  localparam int DW = 64;
  localparam int CW = 32;
  localparam int OW = DW + WW + 4*NB + 1;

  logic clk = 1'b0;
  logic reset;
  logic ibuf_valid;
  logic ibuf_ready;
  logic [WW-1:0] ibuf_wis;
  logic ibuf_wb;
  logic [NB-1:0] ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3;
  logic [DW-1:0] ibuf_data;
  logic wb_valid;
  logic [WW-1:0] wb_wis;
  logic [NB-1:0] wb_rd;
  logic wb_eop;
  logic out_valid;
  logic [OW-1:0] out_data;
  logic out_ready;
  logic [CW-1:0] stall_cycles;

  int errors = 0;
  int checks = 0;
  logic [IR-1:0][NR-1:0] exp_inuse;
  logic [OW-1:0] exp_data;
  logic [CW-1:0] exp_stall;

  issue_scoreboard dut (
    .clk(clk), .reset(reset),
    .ibuf_valid(ibuf_valid), .ibuf_ready(ibuf_ready),
    .ibuf_wis(ibuf_wis), .ibuf_wb(ibuf_wb),
    .ibuf_rd(ibuf_rd), .ibuf_rs1(ibuf_rs1),
    .ibuf_rs2(ibuf_rs2), .ibuf_rs3(ibuf_rs3),
    .ibuf_data(ibuf_data),
    .wb_valid(wb_valid), .wb_wis(wb_wis),
    .wb_rd(wb_rd), .wb_eop(wb_eop),
    .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] pack(
    input logic [WW-1:0] w, input logic b,
    input logic [NB-1:0] d, input logic [NB-1:0] s1,
    input logic [NB-1:0] s2, input logic [NB-1:0] s3,
    input logic [DW-1:0] p);
    return {p, w, b, d, s1, s2, s3};
  endfunction

  task automatic drive(
    input logic [WW-1:0] w, input logic b,
    input logic [NB-1:0] d, input logic [NB-1:0] s1,
    input logic [NB-1:0] s2, input logic [NB-1:0] s3,
    input logic [DW-1:0] p);
    ibuf_valid = 1'b1;
    ibuf_wis = w; ibuf_wb = b; ibuf_rd = d;
    ibuf_rs1 = s1; ibuf_rs2 = s2; ibuf_rs3 = s3;
    ibuf_data = p;
    exp_data = pack(w, b, d, s1, s2, s3, p);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ibuf_valid = 1'b0; ibuf_wis = '0; ibuf_wb = 1'b0;
    ibuf_rd = '0; ibuf_rs1 = '0; ibuf_rs2 = '0; ibuf_rs3 = '0;
    ibuf_data = '0;
    wb_valid = 1'b0; wb_wis = '0; wb_rd = '0; wb_eop = 1'b0;
    out_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    exp_inuse = '0;
    exp_stall = '0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (stall_cycles !== exp_stall) begin
      errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles);
    end
    checks++;
    if (dut.inuse !== exp_inuse) begin
      errors++; $display("FAIL reset_inuse got=%h exp=%h", dut.inuse, exp_inuse);
    end
    step();
  endtask

  task automatic test_issue();
    drive(2'd0, 1'b1, 5'd5, 5'd1, 5'd2, 5'd3, 64'hA5A5_0000_1111_2222);
    @(negedge clk);
    checks++;
    if (ibuf_ready !== 1'b1) begin
      errors++; $display("FAIL issue_ready got=%b exp=1", ibuf_ready);
    end
    step();
    ibuf_valid = 1'b0;
    exp_inuse[0][5] = 1'b1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL issue_out_valid got=%b exp=1", out_valid);
    end
    checks++;
    if (out_data !== exp_data) begin
      errors++; $display("FAIL issue_out_data got=%h exp=%h", out_data, exp_data);
    end
    checks++;
    if (dut.inuse !== exp_inuse) begin
      errors++; $display("FAIL issue_inuse got=%h exp=%h", dut.inuse, exp_inuse);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL issue_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_raw();
    drive(2'd0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 64'hBBBB_0000_0000_0005);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ibuf_ready !== 1'b0) begin
        errors++; $display("FAIL raw_stall%0d got=%b exp=0", i, ibuf_ready);
      end
      step();
      exp_stall++;
    end
    checks++;
    if (stall_cycles !== exp_stall) begin
      errors++; $display("FAIL raw_count got=%0d exp=%0d", stall_cycles, exp_stall);
    end
    wb_valid = 1'b1; wb_wis = 2'd0; wb_rd = 5'd5; wb_eop = 1'b0;
    @(negedge clk);
    checks++;
    if (ibuf_ready !== 1'b0) begin
      errors++; $display("FAIL raw_noneop got=%b exp=0", ibuf_ready);
    end
    step();
    exp_stall++;
    wb_eop = 1'b1;
    @(negedge clk);
    checks++;
    if (ibuf_ready !== 1'b1) begin
      errors++; $display("FAIL raw_bypass got=%b exp=1", ibuf_ready);
    end
    step();
    ibuf_valid = 1'b0; wb_valid = 1'b0; wb_eop = 1'b0;
    exp_inuse[0][5] = 1'b0;
    checks++;
    if (stall_cycles !== exp_stall) begin
      errors++; $display("FAIL raw_count2 got=%0d exp=%0d", stall_cycles, exp_stall);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_data) begin
      errors++; $display("FAIL raw_out got=%b/%h exp=1/%h", out_valid, out_data, exp_data);
    end
    checks++;
    if (dut.inuse !== exp_inuse) begin
      errors++; $display("FAIL raw_inuse got=%h exp=%h", dut.inuse, exp_inuse);
    end
  endtask

  task automatic test_waw();
    drive(2'd1, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0, 64'h7);
    step();
    exp_inuse[1][7] = 1'b1;
    drive(2'd1, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0, 64'h17);
    @(negedge clk);
    checks++;
    if (ibuf_ready !== 1'b0) begin
      errors++; $display("FAIL waw_stall got=%b exp=0", ibuf_ready);
    end
    step();
    exp_stall++;
    drive(2'd2, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0, 64'h27);
    @(negedge clk);
    checks++;
    if (ibuf_ready !== 1'b1) begin
      errors++; $display("FAIL waw_other_wis got=%b exp=1", ibuf_ready);
    end
    step();
    ibuf_valid = 1'b0;
    exp_inuse[2][7] = 1'b1;
    checks++;
    if (dut.inuse !== exp_inuse || stall_cycles !== exp_stall) begin
      errors++; $display("FAIL waw_state got=%h/%0d exp=%h/%0d",
                         dut.inuse, stall_cycles, exp_inuse, exp_stall);
    end
    checks++;
    if (out_data !== exp_data) begin
      errors++; $display("FAIL waw_out got=%h exp=%h", out_data, exp_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(2'(i), 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 64'(32'hC000 + i));
      @(negedge clk);
      checks++;
      if (ibuf_ready !== 1'b1) begin
        errors++; $display("FAIL r0_ready%0d got=%b exp=1", i, ibuf_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_data) begin
        errors++; $display("FAIL r0_out%0d got=%h exp=%h", i, out_data, exp_data);
      end
    end
    ibuf_valid = 1'b0;
    checks++;
    if (dut.inuse !== exp_inuse || stall_cycles !== exp_stall) begin
      errors++; $display("FAIL r0_state got=%h/%0d exp=%h/%0d",
                         dut.inuse, stall_cycles, exp_inuse, exp_stall);
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] held;
    held = exp_data;
    out_ready = 1'b0;
    drive(2'd3, 1'b1, 5'd4, 5'd0, 5'd0, 5'd0, 64'hD4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (ibuf_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
        errors++; $display("FAIL bp_hold%0d got=%b/%b/%h exp=0/1/%h",
                           i, ibuf_ready, out_valid, out_data, held);
      end
      step();
    end
    checks++;
    if (stall_cycles !== exp_stall) begin
      errors++; $display("FAIL bp_count got=%0d exp=%0d", stall_cycles, exp_stall);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ibuf_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got=%b exp=1", ibuf_ready);
    end
    step();
    ibuf_valid = 1'b0;
    exp_inuse[3][4] = 1'b1;
    checks++;
    if (out_data !== exp_data || dut.inuse !== exp_inuse) begin
      errors++; $display("FAIL bp_out got=%h/%h exp=%h/%h",
                         out_data, dut.inuse, exp_data, exp_inuse);
    end
  endtask

  task automatic test_release_acquire();
    drive(2'd0, 1'b1, 5'd9, 5'd0, 5'd0, 5'd0, 64'h9);
    step();
    exp_inuse[0][9] = 1'b1;
    drive(2'd0, 1'b1, 5'd9, 5'd0, 5'd0, 5'd0, 64'h19);
    wb_valid = 1'b1; wb_wis = 2'd0; wb_rd = 5'd9; wb_eop = 1'b1;
    @(negedge clk);
    checks++;
    if (ibuf_ready !== 1'b1) begin
      errors++; $display("FAIL relacq_ready got=%b exp=1", ibuf_ready);
    end
    step();
    ibuf_valid = 1'b0; wb_valid = 1'b0; wb_eop = 1'b0;
    checks++;
    if (dut.inuse !== exp_inuse || out_data !== exp_data) begin
      errors++; $display("FAIL relacq_state got=%h/%h exp=%h/%h",
                         dut.inuse, out_data, exp_inuse, exp_data);
    end
  endtask

  task automatic test_mid_reset();
    checks++;
    if (out_valid !== 1'b0 || dut.inuse === '0) begin
      errors++; $display("FAIL midrst_pre got=%b/%h exp=0/nonzero", out_valid, dut.inuse);
    end
    drive(2'd1, 1'b1, 5'd3, 5'd0, 5'd0, 5'd0, 64'h33);
    step();
    ibuf_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_inuse = '0;
    exp_stall = '0;
    checks++;
    if (out_valid !== 1'b0 || dut.inuse !== exp_inuse || stall_cycles !== exp_stall) begin
      errors++; $display("FAIL midrst_clear got=%b/%h/%0d exp=0/0/0",
                         out_valid, dut.inuse, stall_cycles);
    end
    drive(2'd1, 1'b1, 5'd3, 5'd3, 5'd0, 5'd0, 64'h43);
    @(negedge clk);
    checks++;
    if (ibuf_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_issue got=%b exp=1", ibuf_ready);
    end
    step();
    ibuf_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_data) begin
      errors++; $display("FAIL midrst_out got=%h exp=%h", out_data, exp_data);
    end
  endtask

  initial begin
    test_reset();
    test_issue();
    test_raw();
    test_waw();
    test_back_to_back();
    test_backpressure();
    test_release_acquire();
    step();
    test_mid_reset();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
